// File: rtl/ppl_pkg.sv
// Shared types for the ray pipeline entry stage: FSM state,
// ray payload bundle and default field widths.
package ppl_pkg;

   localparam int PPL_POS_W  = 16;
   localparam int PPL_ADDR_W = 20;
   localparam int PPL_CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [2:0][PPL_POS_W-1:0] pos;
      logic [2:0][PPL_POS_W-1:0] slope;
      logic [PPL_ADDR_W-1:0]     addr;
      logic [PPL_CNT_W-1:0]      cnt;
   } ray_t;

endpackage

// File: rtl/ppl_raster_walker.sv
// Raster x/y/addr walker with incremental per-pixel slope (adders only).
// Ports: start (latch base/du/dv, restart), advance (one pixel issued),
// slope (current pixel slope xyz), addr, last (current pixel is final).
module ppl_raster_walker
   import ppl_pkg::*;
#(
   parameter int H_DISP = 1280,
   parameter int V_DISP = 720,
   parameter int POS_W  = PPL_POS_W,
   parameter int ADDR_W = PPL_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  advance,
   input  logic [2:0][POS_W-1:0] base,
   input  logic [2:0][POS_W-1:0] du,
   input  logic [2:0][POS_W-1:0] dv,
   output logic [2:0][POS_W-1:0] slope,
   output logic [ADDR_W-1:0]     addr,
   output logic                  last
);

   localparam int XW = $clog2(H_DISP + 1);
   localparam int YW = $clog2(V_DISP + 1);

   logic [XW-1:0]            x;
   logic [YW-1:0]            y;
   logic [2:0][POS_W-1:0]    row_slope;
   logic [2:0][POS_W-1:0]    cur_slope;
   logic [2:0][POS_W-1:0]    du_q;
   logic [2:0][POS_W-1:0]    dv_q;
   logic                     x_end;

   assign x_end = (x == XW'(H_DISP - 1));
   assign last  = x_end && (y == YW'(V_DISP - 1));
   assign slope = cur_slope;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         addr      <= '0;
         row_slope <= '0;
         cur_slope <= '0;
         du_q      <= '0;
         dv_q      <= '0;
      end else if (start) begin
         x         <= '0;
         y         <= '0;
         addr      <= '0;
         row_slope <= base;
         cur_slope <= base;
         du_q      <= du;
         dv_q      <= dv;
      end else if (advance) begin
         addr <= addr + 1'b1;
         if (x_end) begin
            x <= '0;
            y <= y + 1'b1;
            // next row starts from the previous row start plus dv
            for (int k = 0; k < 3; k++) begin
               row_slope[k] <= row_slope[k] + dv_q[k];
               cur_slope[k] <= row_slope[k] + dv_q[k];
            end
         end else begin
            x <= x + 1'b1;
            for (int k = 0; k < 3; k++)
               cur_slope[k] <= cur_slope[k] + du_q[k];
         end
      end
   end

endmodule

// File: rtl/ppl_ray_dispatch.sv
// Ray pipeline entry: merges recirculated rays (priority) with raster
// primaries into one output register, credit-throttled per frame.
// Ports: frame_start/cam/slope_*: frame setup; recirc_*: returning rays;
// ray_retire: downstream completion; out_*: ray to march stage;
// busy/frame_done: frame status.
// Optional: PPL_STEP_LIMIT_EN drops recirculated rays at the step limit.
module ppl_ray_dispatch
   import ppl_pkg::*;
#(
   parameter int H_DISP       = 1280,
   parameter int V_DISP       = 720,
   parameter int POS_W        = PPL_POS_W,
   parameter int ADDR_W       = PPL_ADDR_W,
   parameter int CNT_W        = PPL_CNT_W,
   parameter int MAX_INFLIGHT = 64,
   parameter int MAX_STEPS    = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic [POS_W-1:0]  cam_pos_x,
   input  logic [POS_W-1:0]  cam_pos_y,
   input  logic [POS_W-1:0]  cam_pos_z,
   input  logic [POS_W-1:0]  slope_base_x,
   input  logic [POS_W-1:0]  slope_base_y,
   input  logic [POS_W-1:0]  slope_base_z,
   input  logic [POS_W-1:0]  slope_du_x,
   input  logic [POS_W-1:0]  slope_du_y,
   input  logic [POS_W-1:0]  slope_du_z,
   input  logic [POS_W-1:0]  slope_dv_x,
   input  logic [POS_W-1:0]  slope_dv_y,
   input  logic [POS_W-1:0]  slope_dv_z,
   input  logic              recirc_valid,
   output logic              recirc_ready,
   input  logic [POS_W-1:0]  recirc_pos_x,
   input  logic [POS_W-1:0]  recirc_pos_y,
   input  logic [POS_W-1:0]  recirc_pos_z,
   input  logic [POS_W-1:0]  recirc_slope_x,
   input  logic [POS_W-1:0]  recirc_slope_y,
   input  logic [POS_W-1:0]  recirc_slope_z,
   input  logic [ADDR_W-1:0] recirc_addr,
   input  logic [CNT_W-1:0]  recirc_cnt,
   input  logic              ray_retire,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos_x,
   output logic [POS_W-1:0]  out_pos_y,
   output logic [POS_W-1:0]  out_pos_z,
   output logic [POS_W-1:0]  out_slope_x,
   output logic [POS_W-1:0]  out_slope_y,
   output logic [POS_W-1:0]  out_slope_z,
   output logic [ADDR_W-1:0] out_addr,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              busy,
   output logic              frame_done
);

`ifdef PPL_STEP_LIMIT_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   state_t                state;
   ray_t                  out_q;
   logic [2:0][POS_W-1:0] cam_q;
   logic [ADDR_W:0]       inflight;
   logic [ADDR_W+1:0]     infl_add;
   logic [ADDR_W+1:0]     infl_nxt;
   logic [1:0]            dec;
   logic [2:0][POS_W-1:0] w_slope;
   logic [ADDR_W-1:0]     w_addr;
   logic                  w_last;
   logic                  load;
   logic                  drop;
   logic                  take;
   logic                  issue;
   logic                  start;

   assign load  = !out_valid || out_ready;
   assign drop  = STEP_EN && recirc_valid &&
                  (int'(recirc_cnt) >= MAX_STEPS);
   assign take  = load && recirc_valid && !drop;
   assign issue = load && !take && (state == SCAN) &&
                  (inflight < (ADDR_W+1)'(MAX_INFLIGHT));
   assign start = (state == IDLE) && frame_start;

   assign recirc_ready = load;
   assign busy         = (state != IDLE);

   // a dropped ray counts as retired; saturate at zero
   assign dec      = {1'b0, ray_retire} + {1'b0, load && drop};
   assign infl_add = {1'b0, inflight} + {{(ADDR_W+1){1'b0}}, issue};
   assign infl_nxt = (infl_add > {{ADDR_W{1'b0}}, dec}) ?
                     infl_add - {{ADDR_W{1'b0}}, dec} : '0;

   ppl_raster_walker #(
      .H_DISP (H_DISP),
      .V_DISP (V_DISP),
      .POS_W  (POS_W),
      .ADDR_W (ADDR_W)
   ) u_walk (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .advance (issue),
      .base    ({slope_base_z, slope_base_y, slope_base_x}),
      .du      ({slope_du_z, slope_du_y, slope_du_x}),
      .dv      ({slope_dv_z, slope_dv_y, slope_dv_x}),
      .slope   (w_slope),
      .addr    (w_addr),
      .last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_q      <= '0;
         cam_q      <= '0;
         inflight   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         inflight   <= infl_nxt[ADDR_W:0];
         if (take) begin
            out_valid <= 1'b1;
            out_q     <= '{pos:   {recirc_pos_z, recirc_pos_y,
                                   recirc_pos_x},
                           slope: {recirc_slope_z, recirc_slope_y,
                                   recirc_slope_x},
                           addr:  recirc_addr,
                           cnt:   recirc_cnt};
         end else if (issue) begin
            out_valid <= 1'b1;
            out_q     <= '{pos:   cam_q,
                           slope: w_slope,
                           addr:  w_addr,
                           cnt:   '0};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         unique case (state)
            IDLE: if (frame_start) begin
               cam_q <= {cam_pos_z, cam_pos_y, cam_pos_x};
               state <= SCAN;
            end
            SCAN: if (issue && w_last) state <= DRAIN;
            DRAIN: if (inflight == '0 && !out_valid) begin
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_pos_x   = out_q.pos[0];
   assign out_pos_y   = out_q.pos[1];
   assign out_pos_z   = out_q.pos[2];
   assign out_slope_x = out_q.slope[0];
   assign out_slope_y = out_q.slope[1];
   assign out_slope_z = out_q.slope[2];
   assign out_addr    = out_q.addr;
   assign out_cnt     = out_q.cnt;

endmodule

// File: tb/tb_ppl_ray_dispatch.sv
// Randomised bench for ppl_ray_dispatch on a 4x2 raster, 4 credits,
// compared cycle by cycle with a frame-level reference model.
module tb_ppl_ray_dispatch;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int MI = 4;
   localparam int MS = 40;
`ifdef PPL_STEP_LIMIT_EN
   localparam bit STEP = 1'b1;
`else
   localparam bit STEP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [15:0] cam[3];
   logic [15:0] base[3];
   logic [15:0] du[3];
   logic [15:0] dv[3];
   logic        recirc_valid = 1'b0;
   logic        recirc_ready;
   logic [15:0] rpos[3];
   logic [15:0] rsl[3];
   logic [19:0] r_addr;
   logic [5:0]  r_cnt;
   logic        ray_retire = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] opx, opy, opz, osx, osy, osz;
   logic [19:0] out_addr;
   logic [5:0]  out_cnt;
   logic        busy;
   logic        frame_done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   ppl_ray_dispatch #(
      .H_DISP(H), .V_DISP(V), .MAX_INFLIGHT(MI), .MAX_STEPS(MS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .cam_pos_x(cam[0]), .cam_pos_y(cam[1]), .cam_pos_z(cam[2]),
      .slope_base_x(base[0]), .slope_base_y(base[1]),
      .slope_base_z(base[2]),
      .slope_du_x(du[0]), .slope_du_y(du[1]), .slope_du_z(du[2]),
      .slope_dv_x(dv[0]), .slope_dv_y(dv[1]), .slope_dv_z(dv[2]),
      .recirc_valid(recirc_valid), .recirc_ready(recirc_ready),
      .recirc_pos_x(rpos[0]), .recirc_pos_y(rpos[1]),
      .recirc_pos_z(rpos[2]),
      .recirc_slope_x(rsl[0]), .recirc_slope_y(rsl[1]),
      .recirc_slope_z(rsl[2]),
      .recirc_addr(r_addr), .recirc_cnt(r_cnt),
      .ray_retire(ray_retire),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pos_x(opx), .out_pos_y(opy), .out_pos_z(opz),
      .out_slope_x(osx), .out_slope_y(osy), .out_slope_z(osz),
      .out_addr(out_addr), .out_cnt(out_cnt),
      .busy(busy), .frame_done(frame_done)
   );

   // reference model: 0 idle, 1 scanning, 2 draining
   int           m_st   = 0;
   int           m_next = 0;
   int           m_inf  = 0;
   bit           m_ov   = 1'b0;
   bit           m_done = 1'b0;
   logic [127:0] m_pay  = '0;
   logic [15:0]  l_cam[3], l_base[3], l_du[3], l_dv[3];

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // primary ray n: slope = base + col*du + row*dv, wrapped to 16 bits
   function automatic logic [127:0] prim(input int n);
      logic [15:0] s[3];
      for (int k = 0; k < 3; k++)
         s[k] = 16'($signed(l_base[k]) + (n % H) * $signed(l_du[k])
                   + (n / H) * $signed(l_dv[k]));
      return {6'd0, l_cam[0], l_cam[1], l_cam[2],
              s[0], s[1], s[2], 20'(n), 6'd0};
   endfunction

   function automatic logic [127:0] dut_pay();
      return {6'd0, opx, opy, opz, osx, osy, osz, out_addr, out_cnt};
   endfunction

   task automatic set_frame(input int c, b0, b1, b2, u0, u1, u2,
                            v0, v1, v2);
      for (int k = 0; k < 3; k++) cam[k] = 16'(c + k);
      base[0] = 16'(b0); base[1] = 16'(b1); base[2] = 16'(b2);
      du[0] = 16'(u0); du[1] = 16'(u1); du[2] = 16'(u2);
      dv[0] = 16'(v0); dv[1] = 16'(v1); dv[2] = 16'(v2);
   endtask

   task automatic set_recirc(input int a, input int c);
      for (int k = 0; k < 3; k++) begin
         rpos[k] = 16'($urandom);
         rsl[k]  = 16'($urandom);
      end
      r_addr = 20'(a);
      r_cnt  = 6'(c);
   endtask

   task automatic step(input bit fs, rv, ret, ordy, rst);
      bit load, drop, take, issue, ov0;
      int n, inf0;
      rst_n        = !rst;
      frame_start  = fs;
      recirc_valid = rv;
      ray_retire   = ret;
      out_ready    = ordy;
      #1;
      load = !m_ov || ordy;
      chk("recirc_ready", recirc_ready, load);
      if (rst) begin
         m_st = 0; m_next = 0; m_inf = 0;
         m_ov = 0; m_pay = '0; m_done = 0;
      end else begin
         drop  = STEP && rv && (int'(r_cnt) >= MS);
         take  = load && rv && !drop;
         issue = load && !take && m_st == 1 && m_inf < MI;
         ov0   = m_ov;
         inf0  = m_inf;
         n = m_inf + int'(issue) - int'(ret) - int'(load && drop);
         m_inf  = (n < 0) ? 0 : n;
         m_done = 0;
         if (take) begin
            m_ov  = 1;
            m_pay = {6'd0, rpos[0], rpos[1], rpos[2],
                     rsl[0], rsl[1], rsl[2], r_addr, r_cnt};
         end else if (issue) begin
            m_ov  = 1;
            m_pay = prim(m_next);
         end else if (ordy) begin
            m_ov = 0;
         end
         case (m_st)
            0: if (fs) begin
               l_cam = cam; l_base = base; l_du = du; l_dv = dv;
               m_st = 1; m_next = 0;
            end
            1: if (issue && m_next == H * V - 1) m_st = 2;
            default: if (inf0 == 0 && !ov0) begin
               m_done = 1; m_st = 0;
            end
         endcase
         if (issue) m_next++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_st != 0);
      chk("frame_done", frame_done, m_done);
      if (m_ov) chk("payload", dut_pay(), m_pay);
      if (frame_done) done_cnt++;
   endtask

   initial begin
      set_frame(10, 100, 0, 0, 2, 0, 0, 0, 3, 0);
      set_recirc(0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(0, 0, 0, 1, 1);
      chk("rst_addr", out_addr, 0);

      // raster walk until credits run out, then retire to drain
      done_cnt = 0;
      step(1, 0, 0, 1, 0);
      repeat (8) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 1, 0);
         if (out_valid && out_addr == 20'd4)
            chk("addr4_slope", {osx, osy, osz}, {16'd100, 16'd3, 16'd0});
         if (out_valid && out_addr == 20'd7)
            chk("addr7_slope", {osx, osy, osz}, {16'd106, 16'd3, 16'd0});
      end
      repeat (3) step(0, 0, 0, 1, 0);
      chk("done_once", done_cnt, 1);

      // recirculated ray mid-scan, then a 3-cycle downstream stall
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      set_recirc(5, 7);
      step(0, 1, 0, 1, 0);
      chk("recirc_cnt", out_cnt, 7);
      repeat (3) step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 1, 1, 0);

      // reset mid-scan, then restart from pixel 0
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("restart_addr", out_addr, 0);

      // limit-reached ray together with a retire
      set_recirc(3, 40);
      step(0, 1, 1, 1, 0);
      set_recirc(2, 63);
      step(0, 1, 0, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         set_frame($urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom);
         set_recirc($urandom, $urandom_range(0, 63));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 599) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ppl_ray_dispatch.md
Name: ppl_ray_dispatch

Overview:
Generalised ray-pipeline entry stage with valid/ready handshaking on every interface.
- Merges primary rays from an internal raster walker with recirculated rays returning from the march stage; recirculated rays have priority.
- Primary ray slope is computed incrementally from camera basis deltas (adders only, no multipliers).
- Tracks in-flight rays per frame, throttles issue against a credit limit and signals frame completion.
- Sits between the viewport parameter logic and the march/trace stage.

Parameters:
H_DISP, 1280, horizontal pixels per frame
V_DISP, 720, vertical pixels per frame
POS_W, 16, position and slope width (slopes signed)
ADDR_W, 20, pixel address width
CNT_W, 6, block step counter width
MAX_INFLIGHT, 64, maximum rays in flight (1..2^ADDR_W)
MAX_STEPS, 40, step limit used by the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
frame_start  in  1  pulse; starts a frame when IDLE
cam_pos_x/_y/_z  in  POS_W each  camera position, latched at frame_start
slope_base_x/_y/_z  in  POS_W signed each  slope at pixel (0,0), latched
slope_du_x/_y/_z  in  POS_W signed each  slope step per column, latched
slope_dv_x/_y/_z  in  POS_W signed each  slope step per row, latched
recirc_valid  in  1  recirculated ray present
recirc_ready  out  1  recirculated ray accepted
recirc_pos_x/_y/_z, recirc_slope_x/_y/_z  in  POS_W each  recirculated ray state
recirc_addr  in  ADDR_W  recirculated pixel address
recirc_cnt  in  CNT_W  recirculated step count
ray_retire  in  1  pulse; one ray finished downstream
out_valid  out  1  output ray valid
out_ready  in  1  downstream accepts
out_pos_x/_y/_z, out_slope_x/_y/_z  out  POS_W each  output ray
out_addr  out  ADDR_W  output pixel address
out_cnt  out  CNT_W  output step count (0 for primary rays)
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs 0; state IDLE; raster, slope accumulators and inflight counter cleared.
- Applies mid-frame with no drain.

States:
- IDLE: on frame_start, latch cam/base/du/dv; row_slope=cur_slope=base; x=y=0; addr=0; go to SCAN.
- SCAN: issue primary rays. After issuing pixel (H_DISP-1, V_DISP-1), go to DRAIN.
- DRAIN: only recirculated rays pass. When inflight==0 and out_valid==0, pulse frame_done and go to IDLE.
- frame_start is ignored outside IDLE.

Output register (single stage):
- load = !out_valid || out_ready.
- recirc_ready = load (combinational, in any state).
- On load && recirc_valid: register the recirculated ray unchanged.
- Else, on load && state==SCAN && inflight<MAX_INFLIGHT: register a primary ray with pos=cam, slope=cur_slope, addr, cnt=0.
- Else, if out_ready: out_valid<=0.
- Latency: input to out_valid is 1 cycle. Zero bubble under continuous out_ready.

Raster and slope walk (per primary issue):
- x<H_DISP-1: x++, cur_slope+=du.
- x==H_DISP-1: x=0, y++, row_slope+=dv, cur_slope=row_slope+dv.
- addr increments by 1 per issue.
- Slope sums wrap modulo 2^POS_W (two's complement).

Inflight counter (ADDR_W+1 bits):
- +1 per primary issue, -1 per ray_retire; simultaneous events net 0.
- Recirculated rays do not change it.
- A retire arriving at inflight==0 is ignored (saturate at 0).

Optional Feature:
PPL_STEP_LIMIT_EN
- Enabled: a recirculated ray with recirc_cnt>=MAX_STEPS is accepted (recirc_ready=load) but dropped. Nothing is registered, inflight decrements by 1, and a simultaneous ray_retire decrements by 2. The slot may instead carry a primary ray that cycle.
- Disabled: all recirculated rays are forwarded; MAX_STEPS is unused.

Decomposition:
Shared package ppl_pkg:
- state enum (IDLE/SCAN/DRAIN);
- ray payload struct (pos xyz, slope xyz, addr, cnt);
- POS_W, ADDR_W and CNT_W defaults.

Sub-module ppl_raster_walker: x/y/addr counters plus incremental slope accumulators, with advance/last outputs.

Test Plan (H_DISP=4, V_DISP=2, MAX_INFLIGHT=4):
1. frame_start with base=(100,0,0), du=(2,0,0), dv=(0,3,0), out_ready=1, ray_retire=0 -> 4 primary rays, addr 0..3, slope_x 100,102,104,106; then stall (inflight=4).
2. Continue from 1 with ray_retire pulsed each cycle -> rows continue: addr 4 has slope (100,3,0), addr 7 has (106,3,0); state goes to DRAIN; frame_done pulses once after the last retire and out_valid=0.
3. recirc_valid=1 with addr=5, cnt=7 during SCAN -> output that ray with cnt=7; primary issue pauses; addr sequence resumes without a gap.
4. out_ready=0 for 3 cycles with out_valid=1 -> payload held stable, recirc_ready=0, no raster advance.
5. rst_n=0 mid-SCAN at inflight=3 -> next cycle: busy=0, out_valid=0, inflight=0; frame_start restarts at addr 0.
6. PPL_STEP_LIMIT_EN with recirc_cnt=40 plus ray_retire in the same cycle -> ray not output; inflight drops by 2.
